// File: rtl/es_spill_fill_pkg.sv
// rtl/es_spill_fill_pkg.sv - shared types and defaults for the execution-stack spill/fill block
package es_pkg;

    localparam int          WIDTH           = 16;
    localparam logic [15:0] SPILL_BASE_DEF  = 16'hF000;
    localparam int          SPILL_WORDS_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } es_state_e;

endpackage

// File: rtl/es_spill_fill_if.sv
// rtl/es_spill_fill_if.sv - ES push/pop command bundle and spill-region memory port
interface es_spill_fill_if
    import es_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             pop_amt;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] top_a;
    logic [WIDTH-1:0] top_b;
    logic [CW-1:0]    count;
    logic             busy;
    logic             err;
    logic             mem_req;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output push, pop, pop_amt, push_val, mem_rdata, mem_ack,
        input  top_a, top_b, count, busy, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  push, pop, pop_amt, push_val, mem_rdata, mem_ack,
        output top_a, top_b, count, busy, err, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/es_spill_fill_ring_buf.sv
// rtl/es_spill_fill_ring_buf.sv - on-chip circular stack store with top and bottom access
module es_ring_buf
    import es_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       top_pop_n_i,
    input  logic             top_push_i,
    input  logic [WIDTH-1:0] top_val_i,
    input  logic             bot_remove_i,
    input  logic             bot_insert_i,
    input  logic [WIDTH-1:0] bot_val_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] top_a_o,
    output logic [WIDTH-1:0] top_b_o,
    output logic [WIDTH-1:0] bot_val_o
);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PW-1:0]    bot_ptr_q;
    logic [PW-1:0]    top_ptr_q;
    logic [CW-1:0]    count_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    ins_ptr;

    // top_ptr is the next free slot; a combined pop+push writes where the popped entries were
    assign wr_ptr  = top_ptr_q - PW'(top_pop_n_i);
    assign ins_ptr = bot_ptr_q - PW'(1);

    // Pointer and occupancy update; top and bottom operations never coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bot_ptr_q <= '0;
            top_ptr_q <= '0;
            count_q   <= '0;
        end else if (bot_remove_i) begin
            bot_ptr_q <= bot_ptr_q + PW'(1);
            count_q   <= count_q - CW'(1);
        end else if (bot_insert_i) begin
            bot_ptr_q <= ins_ptr;
            count_q   <= count_q + CW'(1);
        end else begin
            top_ptr_q <= wr_ptr + PW'(top_push_i);
            count_q   <= count_q - CW'(top_pop_n_i) + CW'(top_push_i);
        end
    end

    // Entry storage, no reset: occupancy gates every read that matters
    always_ff @(posedge clk_i) begin
        if (top_push_i) begin
            slot_q[wr_ptr] <= top_val_i;
        end
        if (bot_insert_i) begin
            slot_q[ins_ptr] <= bot_val_i;
        end
    end

    assign count_o   = count_q;
    assign top_a_o   = (count_q >= CW'(1)) ? slot_q[top_ptr_q - PW'(1)] : '0;
    assign top_b_o   = (count_q >= CW'(2)) ? slot_q[top_ptr_q - PW'(2)] : '0;
    assign bot_val_o = slot_q[bot_ptr_q];

endmodule

// File: rtl/es_spill_fill.sv
// rtl/es_spill_fill.sv - execution-stack backing store with watermark spill/fill (option: ES_SPILL_STATS_EN)
module es_spill_fill
    import es_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          HI_WM       = 6,
    parameter int          LO_WM       = 2,
    parameter logic [15:0] SPILL_BASE  = SPILL_BASE_DEF,
    parameter int          SPILL_WORDS = SPILL_WORDS_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    es_spill_fill_if.slave     es
`ifdef ES_SPILL_STATS_EN
    ,
    output logic [15:0]        spill_events_o,
    output logic [15:0]        fill_events_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SPILL_WORDS + 1);
    localparam logic [CW-1:0] HI_C    = CW'(HI_WM);
    localparam logic [CW-1:0] LO_C    = CW'(LO_WM);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] WORDS_C = SW'(SPILL_WORDS);

    es_state_e        state_q;
    logic [SW-1:0]    spill_cnt_q;
    logic             err_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [15:0]      mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] bot_val;
    logic             due_spill;
    logic             due_fill;
    logic             busy;
    logic             accept;
    logic [1:0]       pop_n;
    logic             underflow;
    logic             overflow;
    logic             do_top;
    logic             spill_ack;
    logic             fill_ack;

    // Watermarks look at registered occupancy, so a transfer is due one cycle after the command
    assign due_spill = (count > HI_C) && (spill_cnt_q < WORDS_C);
    assign due_fill  = (count < LO_C) && (spill_cnt_q != '0);
    assign busy      = (state_q != IDLE) || due_spill || due_fill;
    assign accept    = !busy;

    assign pop_n     = es.pop ? (es.pop_amt ? 2'd2 : 2'd1) : 2'd0;
    assign underflow = accept && es.pop && (count < CW'(pop_n));
    assign overflow  = accept && es.push && !es.pop && (count == DEPTH_C);
    assign do_top    = accept && !underflow && !overflow;

    assign spill_ack = (state_q == SPILL) && es.mem_ack;
    assign fill_ack  = (state_q == FILL) && es.mem_ack;

    es_ring_buf #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .top_pop_n_i  (do_top ? pop_n : 2'd0),
        .top_push_i   (do_top && es.push),
        .top_val_i    (es.push_val),
        .bot_remove_i (spill_ack),
        .bot_insert_i (fill_ack),
        .bot_val_i    (es.mem_rdata),
        .count_o      (count),
        .top_a_o      (es.top_a),
        .top_b_o      (es.top_b),
        .bot_val_o    (bot_val)
    );

    // Transfer FSM: request fields are latched on entry and held until the acknowledge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            spill_cnt_q <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (underflow || overflow) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (due_spill) begin
                        state_q     <= SPILL;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= SPILL_BASE + 16'(spill_cnt_q);
                        mem_wdata_q <= bot_val;
                    end else if (due_fill) begin
                        state_q     <= FILL;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= SPILL_BASE + 16'(spill_cnt_q) - 16'd1;
                        mem_wdata_q <= '0;
                    end
                end
                SPILL: begin
                    if (es.mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        spill_cnt_q <= spill_cnt_q + SW'(1);
                    end
                end
                FILL: begin
                    if (es.mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        spill_cnt_q <= spill_cnt_q - SW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign es.count     = count;
    assign es.busy      = busy;
    assign es.err       = err_q;
    assign es.mem_req   = mem_req_q;
    assign es.mem_we    = mem_we_q;
    assign es.mem_addr  = mem_addr_q;
    assign es.mem_wdata = mem_wdata_q;

`ifdef ES_SPILL_STATS_EN
    logic [15:0] spill_ev_q;
    logic [15:0] fill_ev_q;

    // Saturating transfer counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spill_ev_q <= '0;
            fill_ev_q  <= '0;
        end else begin
            if (spill_ack && (spill_ev_q != 16'hFFFF)) begin
                spill_ev_q <= spill_ev_q + 16'd1;
            end
            if (fill_ack && (fill_ev_q != 16'hFFFF)) begin
                fill_ev_q <= fill_ev_q + 16'd1;
            end
        end
    end

    assign spill_events_o = spill_ev_q;
    assign fill_events_o  = fill_ev_q;
`endif

endmodule
